// File: rtl/systolic_skew_feeder.sv
// Skews one unskewed k-step per handshake into diagonal wavefront order for the 8x8 PE cluster.
// Lane i is delayed by i cycles, and per-row done strobes travel alongside the activation lanes.
module systolic_skew_feeder #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int MAX_K  = 256,
  parameter int CNT_W  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DATA_W-1:0] in_act,
  input  logic [N*DATA_W-1:0] in_wgt,
  output logic [N*DATA_W-1:0] act_out,
  output logic [N*DATA_W-1:0] wgt_out,
  output logic [N-1:0]        done_out,
  output logic                busy,
  output logic                tile_done,
  output logic [CNT_W-1:0]    beat_count,
  output logic                err_overflow
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam int FL_W = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [CNT_W-1:0] MAX_K_C = CNT_W'(MAX_K);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(N - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic             tile_done_q, tile_done_d;
  logic             err_q, err_d;
  logic             accept, hit_max, last_eff;

  assign in_ready = en && (state_q != FLUSH);
  assign accept   = in_valid && in_ready;
  assign cnt_next = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  // The MAX_K-th beat closes the tile even without in_last.
  assign hit_max  = (cnt_next == MAX_K_C);
  assign last_eff = in_last || hit_max;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fl_d        = fl_q;
    tile_done_d = 1'b0;
    err_d       = err_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      fl_d    = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            cnt_d = cnt_next;
            fl_d  = '0;
            if (last_eff) begin
              state_d = FLUSH;
              if (!in_last) err_d = 1'b1;
            end else begin
              state_d = STREAM;
            end
          end
        end
        FLUSH: begin
          // N-1 edges after the last beat the deepest lane has shown it.
          if (fl_q == FL_LAST) begin
            state_d     = IDLE;
            tile_done_d = 1'b1;
          end else begin
            fl_d = fl_q + FL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fl_q        <= '0;
      tile_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fl_q        <= fl_d;
      tile_done_q <= tile_done_d;
      err_q       <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign tile_done    = tile_done_q;
  assign beat_count   = cnt_q;
  assign err_overflow = err_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DATA_W-1:0] act_p [i+1];
    logic signed [DATA_W-1:0] wgt_p [i+1];
    logic [i:0]               done_p;

    // Stage 0 loads the lane on an accepted beat and zero otherwise; stages 1..i delay it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          act_p[s] <= '0;
          wgt_p[s] <= '0;
        end
        done_p <= '0;
      end else if (!en) begin
        for (int s = 0; s <= i; s++) begin
          act_p[s] <= '0;
          wgt_p[s] <= '0;
        end
        done_p <= '0;
      end else begin
        act_p[0]  <= accept ? in_act[i*DATA_W +: DATA_W] : '0;
        wgt_p[0]  <= accept ? in_wgt[i*DATA_W +: DATA_W] : '0;
        done_p[0] <= accept && last_eff;
        for (int s = 1; s <= i; s++) begin
          act_p[s]  <= act_p[s-1];
          wgt_p[s]  <= wgt_p[s-1];
          done_p[s] <= done_p[s-1];
        end
      end
    end

    assign act_out[i*DATA_W +: DATA_W] = act_p[i];
    assign wgt_out[i*DATA_W +: DATA_W] = wgt_p[i];
    assign done_out[i]                 = done_p[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: an edge-indexed history model of accepted beats predicts
// every output each cycle, and directed scenarios pin the model with literal expectations.
module tb_systolic_skew_feeder;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int MAX_K  = 256;
  localparam int CNT_W  = 9;
  localparam int W      = N * DATA_W;
  localparam int HL     = 2048;

  logic             clk = 1'b0;
  logic             rst_n, en, in_valid, in_last;
  logic [W-1:0]     in_act, in_wgt;
  logic             in_ready;
  logic [W-1:0]     act_out, wgt_out;
  logic [N-1:0]     done_out;
  logic             busy, tile_done, err_overflow;
  logic [CNT_W-1:0] beat_count;

  systolic_skew_feeder #(.DATA_W(DATA_W), .N(N), .MAX_K(MAX_K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_act(in_act), .in_wgt(in_wgt), .act_out(act_out),
    .wgt_out(wgt_out), .done_out(done_out), .busy(busy), .tile_done(tile_done),
    .beat_count(beat_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Model: what was accepted on each edge, and the tile bookkeeping derived from it.
  int           ecount = 0;
  int           last_clr = 0;
  int           m_cnt = 0;
  int           m_last_edge = 0;
  int           m_td = -1;
  bit           m_busy = 0, m_flushing = 0, m_err = 0;
  bit           h_acc [HL];
  bit           h_done [HL];
  logic [W-1:0] h_act [HL];
  logic [W-1:0] h_wgt [HL];

  always @(posedge clk) begin : model
    bit acc, le;
    ecount++;
    if (ecount >= HL) begin
      $display("FAIL model_history got=%0d want<%0d", ecount, HL);
      $fatal(1);
    end
    h_acc[ecount]  = 1'b0;
    h_done[ecount] = 1'b0;
    if (!rst_n || !en) begin
      last_clr = ecount; m_busy = 0; m_flushing = 0; m_cnt = 0; m_err = 0; m_td = -1;
    end else begin
      acc = in_valid && !m_flushing;
      if (acc) begin
        if (!m_busy) begin m_busy = 1; m_cnt = 1; end
        else m_cnt++;
        le = in_last || (m_cnt == MAX_K);
        if (le) begin
          m_flushing = 1; m_last_edge = ecount;
          if (!in_last) m_err = 1;
        end
        h_acc[ecount] = 1'b1; h_done[ecount] = le;
        h_act[ecount] = in_act; h_wgt[ecount] = in_wgt;
      end else if (m_flushing && ecount == m_last_edge + N - 1) begin
        m_flushing = 0; m_busy = 0; m_td = ecount;
      end
    end
  end

  always @(negedge rst_n) begin
    last_clr = ecount; m_busy = 0; m_flushing = 0; m_cnt = 0; m_err = 0; m_td = -1;
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] ea, ew;
    logic [N-1:0] ed;
    int e;
    ea = '0; ew = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      e = ecount - i;
      if (e >= 1 && e > last_clr && h_acc[e]) begin
        ea[i*DATA_W +: DATA_W] = h_act[e][i*DATA_W +: DATA_W];
        ew[i*DATA_W +: DATA_W] = h_wgt[e][i*DATA_W +: DATA_W];
        ed[i] = h_done[e];
      end
    end
    check_w("act_out", act_out, ea);
    check_w("wgt_out", wgt_out, ew);
    check("done_out", int'(done_out), int'(ed));
    check("tile_done", int'(tile_done), int'(m_td == ecount));
    check("beat_count", int'(beat_count), m_cnt);
    check("err_overflow", int'(err_overflow), int'(m_err));
    check("in_ready", int'(in_ready), int'(en && !m_flushing));
    if (m_td != ecount) check("busy", int'(busy), int'(m_busy));
  end

  function automatic logic [W-1:0] lanes(input int base, input int step);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + step * i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0; in_wgt = '0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] w, input logic last,
                      output int e);
    int tries = 0;
    in_valid = 1'b1; in_act = a; in_wgt = w; in_last = last;
    while (!in_ready && tries < 400) begin
      tick();
      tries++;
    end
    if (tries >= 400) begin
      n_total++; n_bad++;
      $display("FAIL beat_accept_timeout got=%0d want<400", tries);
    end
    tick();
    e = ecount;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic single_beat_scenario(input string tag);
    int e;
    beat(lanes(16'h0100, 1), lanes(16'h0200, 1), 1'b1, e);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check({tag, "_act_lane"}, int'(act_out[i*DATA_W +: DATA_W]), 16'h0100 + i);
      check({tag, "_wgt_lane"}, int'(wgt_out[i*DATA_W +: DATA_W]), 16'h0200 + i);
      check({tag, "_done_lane"}, int'(done_out), 1 << i);
    end
    check({tag, "_tile_done"}, int'(tile_done), 1);
    check({tag, "_beat_count"}, int'(beat_count), 1);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin : stimulus
    int e, e0;
    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_act = '0; in_wgt = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_w("rst_act_out", act_out, '0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_beat_count", int'(beat_count), 0);
    rst_n = 1'b1;
    tick();

    single_beat_scenario("single");
    idle(2);

    // Back-to-back 8-beat tile, then the next tile as early as it can go.
    for (int k = 0; k < N; k++) begin
      beat(lanes(16 * k, 1), lanes(16'h1000 + 16 * k, 1), k == N - 1, e);
      if (k == 0) e0 = e;
    end
    check("b2b_last_edge", e, e0 + 7);
    while (ecount < e0 + 14) @(negedge clk);
    check("b2b_done7", int'(done_out), 8'h80);
    check("b2b_tile_done", int'(tile_done), 1);
    check("b2b_lane7_val", int'(act_out[7*DATA_W +: DATA_W]), 16'h0077);
    beat(lanes(16'h0300, 1), lanes(16'h0400, 1), 1'b1, e);
    check("next_tile_edge", e, e0 + 15);
    idle(N + 1);

    // Same tile with bubbles after beats 2 and 5.
    for (int k = 0; k < N; k++) begin
      beat(lanes(16'h0500 + 16 * k, 1), lanes(16'h0600 + 16 * k, 1), k == N - 1, e);
      if (k == 2 || k == 5) idle(1);
    end
    idle(N + 1);
    check("gap_beat_count", int'(beat_count), 8);

    // MAX_K beats without in_last.
    for (int k = 0; k < MAX_K; k++) beat(lanes(8 * k, 1), lanes(8 * k + 3, 1), 1'b0, e);
    while (ecount < e + N - 1) @(negedge clk);
    check("ovf_tile_done", int'(tile_done), 1);
    check("ovf_beat_count", int'(beat_count), 256);
    check("ovf_err", int'(err_overflow), 1);
    idle(2);
    beat(lanes(16'h0700, 1), lanes(16'h0800, 1), 1'b1, e);
    idle(N + 1);
    check("ovf_err_sticky", int'(err_overflow), 1);

    // en dropped two cycles into FLUSH.
    beat(lanes(16'h0900, 1), lanes(16'h0a00, 1), 1'b0, e);
    beat(lanes(16'h0910, 1), lanes(16'h0a10, 1), 1'b0, e);
    beat(lanes(16'h0920, 1), lanes(16'h0a20, 1), 1'b1, e);
    tick(); tick();
    en = 1'b0;
    tick();
    @(negedge clk);
    check_w("en_clr_act", act_out, '0);
    check_w("en_clr_wgt", wgt_out, '0);
    check("en_clr_done", int'(done_out), 0);
    check("en_clr_count", int'(beat_count), 0);
    check("en_clr_err", int'(err_overflow), 0);
    tick();
    en = 1'b1;
    #1 check("en_back_ready", int'(in_ready), 1);
    idle(N + 1);

    // Asynchronous reset between edges mid-STREAM.
    beat(lanes(16'h0b00, 1), lanes(16'h0c00, 1), 1'b0, e);
    beat(lanes(16'h0b10, 1), lanes(16'h0c10, 1), 1'b0, e);
    beat(lanes(16'h0b20, 1), lanes(16'h0c20, 1), 1'b0, e);
    #1 rst_n = 1'b0;
    #1;
    check_w("arst_act", act_out, '0);
    check_w("arst_wgt", wgt_out, '0);
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(beat_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    single_beat_scenario("post_rst");
    idle(N + 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
